// File: rtl/param_fifo_pkg.sv
// Shared helpers for the parametrised FIFO: pointer wrap rule and count width.
package param_fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Advance a pointer over 0..depth-1; depth need not be a power of two.
  function automatic int ptr_next(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer register over 0..DEPTH-1 with an increment enable.
module fifo_ptr
  import param_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= PW'(ptr_next(int'(ptr), DEPTH));
    end
  end

endmodule

// File: rtl/param_fifo.sv
// Synchronous FWFT FIFO with valid/ready on both sides, occupancy count,
// almost-full flag and sticky overflow flag.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        almost_full,
  output logic                        overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(DEPTH);

  if (WIDTH < 1) begin : g_bad_width
    $error("param_fifo: WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("param_fifo: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("param_fifo: AFULL_THRESH must be in 1..DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  // Handshake flags depend on count only, so no input-to-output comb path.
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign almost_full = (count >= CW'(AFULL_THRESH));

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // Storage is intentionally not reset; out_data is meaningless while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  assign out_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (in_valid && full) begin
      overflow <= 1'b1;
    end
  end

  // Producer must hold a stalled transfer unchanged until it is accepted.
  a_in_hold: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready) |=> (in_valid && $stable(in_data)));

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: scoreboard queue with a decoupled output
// monitor on the DEPTH=4 instance, plus inline checks on a DEPTH=3 instance.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       almost_full;
  logic       overflow;

  logic       iv3 = 1'b0;
  logic       ir3;
  logic [7:0] d3 = 8'h00;
  logic       ov3;
  logic       or3 = 1'b0;
  logic [7:0] od3;
  logic [1:0] cnt3;
  logic       af3;
  logic       of3;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  param_fifo #(.WIDTH(8), .DEPTH(4), .AFULL_THRESH(3)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .count       (count),
    .almost_full (almost_full),
    .overflow    (overflow)
  );

  param_fifo #(.WIDTH(8), .DEPTH(3), .AFULL_THRESH(2)) u_dut3 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (iv3),
    .in_ready    (ir3),
    .in_data     (d3),
    .out_valid   (ov3),
    .out_ready   (or3),
    .out_data    (od3),
    .count       (cnt3),
    .almost_full (af3),
    .overflow    (of3)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; exp_push marks a transfer the bench expects to be accepted.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy,
                       input logic exp_push);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    if (exp_push) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted output beat must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got %0h with empty scoreboard", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL pop_data: got %0h expected %0h at %0t", out_data, e, $time);
        end
      end
    end
  end

  initial begin
    logic [7:0] fill [4];
    logic       af_exp [4];
    logic       rdy_exp [4];
    fill    = '{8'h11, 8'h22, 8'h33, 8'h44};
    af_exp  = '{1'b0, 1'b0, 1'b1, 1'b1};
    rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b0};

    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_afull", int'(almost_full), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Empty push: no bypass in the push cycle, visible the next cycle.
    in_valid = 1'b1;
    in_data  = 8'h5A;
    exp_q.push_back(8'h5A);
    #1;
    chk("empty_push_no_bypass", int'(out_valid), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("empty_push_valid_next", int'(out_valid), 1);
    chk("empty_push_data_next", int'(out_data), 8'h5A);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty_after_pop", int'(count), 0);

    // Fill to full with consumer stalled.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, fill[i], 1'b0, 1'b1);
      chk("fill_count", int'(count), i + 1);
      chk("fill_afull", int'(almost_full), int'(af_exp[i]));
      chk("fill_in_ready", int'(in_ready), int'(rdy_exp[i]));
    end

    // Full with push+pop offered: only the pop happens, overflow latches.
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("full_pop_only_count", int'(count), 3);
    chk("overflow_set", int'(overflow), 1);
    cycle(1'b1, 8'h55, 1'b0, 1'b1);
    chk("held_push_count", int'(count), 4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained_count", int'(count), 0);
    chk("drained_out_valid", int'(out_valid), 0);
    chk("overflow_sticky", int'(overflow), 1);

    // Asynchronous reset mid-stream at count=3.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1);
    chk("pre_rst_count", int'(count), 3);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_in_ready", int'(in_ready), 1);
    chk("async_rst_overflow", int'(overflow), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 8'hA5, 1'b0, 1'b1);
    chk("post_rst_valid", int'(out_valid), 1);
    chk("post_rst_data", int'(out_data), 8'hA5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Steady push+pop for 20 cycles from count=2.
    cycle(1'b1, 8'h01, 1'b0, 1'b1);
    cycle(1'b1, 8'h02, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'h03 + 8'(i), 1'b1, 1'b1);
      chk("steady_count", int'(count), 2);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    out_ready = 1'b0;
    chk("steady_drained", int'(count), 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    // DEPTH=3 instance: 7 push/pop pairs wrap the pointers 2->0.
    for (int i = 0; i < 7; i++) begin
      iv3 = 1'b1;
      d3  = 8'h30 + 8'(i);
      @(posedge clk);
      #1;
      iv3 = 1'b0;
      chk("d3_valid", int'(ov3), 1);
      chk("d3_data", int'(od3), 8'h30 + i);
      or3 = 1'b1;
      @(posedge clk);
      #1;
      or3 = 1'b0;
      chk("d3_empty", int'(ov3), 0);
    end
    for (int i = 0; i < 3; i++) begin
      iv3 = 1'b1;
      d3  = 8'h70 + 8'(i);
      @(posedge clk);
      #1;
    end
    iv3 = 1'b0;
    chk("d3_full_count", int'(cnt3), 3);
    chk("d3_full_ready", int'(ir3), 0);
    chk("d3_afull", int'(af3), 1);
    or3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("d3_drain_data", int'(od3), 8'h70 + i);
      @(posedge clk);
      #1;
    end
    or3 = 1'b0;
    chk("d3_drained", int'(cnt3), 0);
    chk("d3_no_overflow", int'(of3), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
